// File: rtl/im_fetch_pkg.sv
// Shared types and default sizing for the instruction-fetch unit.
package im_fetch_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  // Fetch sequencer states. HALT is only reachable in the wrap-stop build.
  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } fetch_state_e;

  // One prefetch entry at the default widths: the captured word and its address.
  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] instr;
    logic [DEFAULT_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/im_prefetch_fifo.sv
// First-word-fall-through prefetch FIFO. Read/write pointers carry one extra
// wrap bit so full and empty are distinguished without a separate counter.
// Handshake: push is honoured only when !full, pop only when !empty; flush
// empties the FIFO and takes priority over push and pop on the same edge.
module im_prefetch_fifo
  import im_fetch_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DATA_WIDTH + DEFAULT_ADDR_WIDTH,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Occupancy and status flags come straight from the pointer difference.
  always_comb begin
    count     = wr_ptr_q - rd_ptr_q;
    full      = (count == DEPTH_CNT);
    empty     = (count == '0);
    head_data = mem_q[rd_ptr_q[PTR_W-1:0]];
  end

  // Next pointer values and storage write; flush resets both pointers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Pointer registers; reset discards every stored entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage needs no reset: the pointers decide what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/im_fetch_unit.sv
// Instruction-fetch master: drives the instruction RAM read port, captures the
// combinational read data into a prefetch FIFO and presents it to decode.
// Optional build macro IM_FETCH_WRAP_STOP_EN: stop fetching after the top
// address is issued (HALT, fetch_done=1) instead of wrapping the pc to 0.
// Decode handshake: an entry transfers on an edge where instr_valid and
// instr_ready are both high and redirect_valid is low; a redirect flushes the
// FIFO, so a head shown during the redirect cycle is never consumed.
module im_fetch_unit
  import im_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int                    FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic [ADDR_WIDTH-1:0] im_address,
  output logic                  im_cs,
  output logic                  im_we,
  output logic                  im_oe,
  input  logic [DATA_WIDTH-1:0] im_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  output logic                  fetch_done
);

  localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  fetch_state_e          state_q, state_d;

  logic                  issue;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [ENTRY_W-1:0]    head_data;
  logic                  head_live;

  // Issue/pop decisions. Reset is folded in so the RAM port goes quiet the
  // moment reset rises, not at the next edge.
  always_comb begin
    issue = !reset && (state_q == ST_FETCH) && fetch_en && !fifo_full && !redirect_valid;
    pop   = instr_valid && instr_ready && !redirect_valid;
  end

  // RAM port-1 controls: read-only master addressed by the pc.
  always_comb begin
    im_address = pc_q;
    im_cs      = issue;
    im_oe      = issue;
    im_we      = 1'b0;
  end

  // Next pc and sequencer state; a redirect overrides everything else.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (redirect_valid) begin
      pc_d    = redirect_addr;
      state_d = ST_FETCH;
    end else if (issue) begin
      pc_d = pc_q + PC_ONE;
`ifdef IM_FETCH_WRAP_STOP_EN
      if (pc_q == '1) begin
        state_d = ST_HALT;
      end
`endif
    end
  end

  // pc and state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_ADDR;
      state_q <= ST_FETCH;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  // fetch_done is the registered HALT state, so it rises the cycle after the
  // top address is issued and clears with a redirect or reset.
  always_comb begin
`ifdef IM_FETCH_WRAP_STOP_EN
    fetch_done = (state_q == ST_HALT);
`else
    fetch_done = 1'b0;
`endif
  end

  im_prefetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (issue),
    .push_data ({im_data, pc_q}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Decode-facing head: stale storage is masked to zero when nothing is live.
  always_comb begin
    head_live   = (fifo_count != '0);
    instr_valid = !fifo_empty;
    instr       = head_live ? head_data[ENTRY_W-1:ADDR_WIDTH] : '0;
    instr_pc    = head_live ? head_data[ADDR_WIDTH-1:0] : '0;
  end

endmodule
